// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Types and constants shared by the FPU compare pipeline:
//   fcmp_op_t : compare opcode (FEQ / FLT / FLE / reserved)
//   EXP_W     : single-precision exponent width
//   MAN_W     : single-precision mantissa width
//   fclass_t  : per-operand classification produced by fclass
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef enum logic [1:0] {
        FEQ  = 2'd0,
        FLT  = 2'd1,
        FLE  = 2'd2,
        RSVD = 2'd3
    } fcmp_op_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
        logic sign;
    } fclass_t;

endpackage

// File: rtl/fcmp_pipe_if.sv
// -----------------------------------------------------------------------------
// fcmp_pipe_if
// Request/response bundle of the FP compare unit.
//   in_valid/in_ready  : request handshake, with in_op/in_x1/in_x2/in_tag
//   out_valid/out_ready: result handshake, with out_y/out_tag
//   nv / nv_clr        : sticky invalid flag and its synchronous clear
// master = requester/consumer side, slave = the compare unit.
// -----------------------------------------------------------------------------
interface fcmp_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             nv;
    logic             nv_clr;

    modport master (
        output in_valid, in_op, in_x1, in_x2, in_tag, out_ready, nv_clr,
        input  in_ready, out_valid, out_y, out_tag, nv
    );

    modport slave (
        input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready, nv_clr,
        output in_ready, out_valid, out_y, out_tag, nv
    );
endinterface

// File: rtl/fclass.sv
// -----------------------------------------------------------------------------
// fclass
// Combinational classifier for one single-precision operand.
//   x   : operand bits
//   cls : {nan, snan, zero, sign}
// Denormals are not flagged; they are compared by bit pattern downstream.
// -----------------------------------------------------------------------------
module fclass
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    output fclass_t     cls
);
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;
    logic             nan_s;

    assign exp_s = x[30:23];
    assign man_s = x[22:0];
    assign nan_s = (exp_s == 8'hFF) && (man_s != 23'd0);

    // pack the classification; quiet bit is mantissa MSB
    always_comb begin
        cls.nan  = nan_s;
        cls.snan = nan_s & ~man_s[22];
        cls.zero = (exp_s == 8'd0) && (man_s == 23'd0);
        cls.sign = x[31];
    end
endmodule

// File: rtl/fcmp_pipe.sv
// -----------------------------------------------------------------------------
// fcmp_pipe
// Two-stage pipelined single-precision FEQ/FLT/FLE unit with valid/ready
// backpressure, destination tag pass-through and a sticky NV flag.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : fcmp_pipe_if.slave (request, result, nv, nv_clr)
// Stage 1 registers the request and classifies operands; stage 2 computes
// the result and holds out_y/out_tag/out_valid until consumed.
// -----------------------------------------------------------------------------
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rstn,
    fcmp_pipe_if.slave    bus
);
    // stage 1 registers
    logic             s1_valid_r;
    fcmp_op_t         s1_op_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [31:0]      s1_x1_r;
    logic [31:0]      s1_x2_r;

    // stage 2 / output registers
    logic             s2_valid_r;
    logic             s2_nv_r;
    logic [31:0]      out_y_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             nv_r;

    logic    s1_adv_s;
    logic    s2_adv_s;
    logic    out_fire_s;
    fclass_t c1_s;
    fclass_t c2_s;
    logic    any_nan_s;
    logic    any_snan_s;
    logic    eq_s;
    logic    lt_s;
    logic    res_s;
    logic    nv_set_s;

    assign s2_adv_s   = ~s2_valid_r | bus.out_ready;
    assign s1_adv_s   = ~s1_valid_r | s2_adv_s;
    assign out_fire_s = s2_valid_r & bus.out_ready;

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.nv        = nv_r;

    // stage 1: capture request whenever the slot is free or moving on
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= FEQ;
            s1_tag_r   <= '0;
            s1_x1_r    <= 32'd0;
            s1_x2_r    <= 32'd0;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_r  <= fcmp_op_t'(bus.in_op);
                s1_tag_r <= bus.in_tag;
                s1_x1_r  <= bus.in_x1;
                s1_x2_r  <= bus.in_x2;
            end
        end
    end

    fclass u_cls1 (.x(s1_x1_r), .cls(c1_s));
    fclass u_cls2 (.x(s1_x2_r), .cls(c2_s));

    // compare: sign-magnitude ordering, +0 == -0, NaN forces res = 0
    always_comb begin
        eq_s       = 1'b0;
        lt_s       = 1'b0;
        res_s      = 1'b0;
        nv_set_s   = 1'b0;
        any_nan_s  = c1_s.nan | c2_s.nan;
        any_snan_s = c1_s.snan | c2_s.snan;
        if (c1_s.zero && c2_s.zero) begin
            eq_s = 1'b1;
            lt_s = 1'b0;
        end else begin
            eq_s = (s1_x1_r == s1_x2_r);
            if (c1_s.sign != c2_s.sign) begin
                lt_s = c1_s.sign;
            end else if (!c1_s.sign) begin
                lt_s = (s1_x1_r[30:0] < s1_x2_r[30:0]);
            end else begin
                lt_s = (s1_x1_r[30:0] > s1_x2_r[30:0]);
            end
        end
        case (s1_op_r)
            FEQ: begin
                res_s    = ~any_nan_s & eq_s;
                nv_set_s = any_snan_s;
            end
            FLT: begin
                res_s    = ~any_nan_s & lt_s;
                nv_set_s = any_nan_s;
            end
            FLE: begin
                res_s    = ~any_nan_s & (lt_s | eq_s);
                nv_set_s = any_nan_s;
            end
            default: begin
                res_s    = 1'b0;
                nv_set_s = 1'b0;
            end
        endcase
    end

    // stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_r <= 1'b0;
            s2_nv_r    <= 1'b0;
            out_y_r    <= 32'd0;
            out_tag_r  <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_y_r   <= {31'd0, res_s};
                out_tag_r <= s1_tag_r;
                s2_nv_r   <= nv_set_s;
            end
        end
    end

    // sticky NV: raised when an offending op is handed off; set beats clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nv_r <= 1'b0;
        end else begin
            nv_r <= (out_fire_s & s2_nv_r) | (nv_r & ~bus.nv_clr);
        end
    end
endmodule

// File: tb/tb_fcmp_pipe.sv
// -----------------------------------------------------------------------------
// tb_fcmp_pipe
// Directed bench for fcmp_pipe: reset values, basic compares, signs/zeros,
// NaN/NV handling, backpressure, reset mid-flight and a random stream
// checked against an ordering-key reference model.
// -----------------------------------------------------------------------------
module tb_fcmp_pipe;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fcmp_pipe_if #(.TAG_W(5)) bus ();

    fcmp_pipe #(.TAG_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] y;
        logic [4:0]  tag;
        logic        nv;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   outs  = 0;
    logic exp_nv = 1'b0;
    exp_t sb[$];

    logic [31:0] sp [0:7] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                              32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // reference: map each operand to a signed ordering key (-0 and +0 coincide)
    function automatic logic [1:0] ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic   an, bn, asn, bsn, lt, eq, res, nvf;
        longint ka, kb;
        an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        asn = an && !a[22];
        bsn = bn && !b[22];
        ka  = longint'({33'd0, a[30:0]});
        kb  = longint'({33'd0, b[30:0]});
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        lt = (ka < kb);
        eq = (ka == kb);
        case (op)
            2'd0:    begin res = eq;      nvf = asn | bsn; end
            2'd1:    begin res = lt;      nvf = an | bn;   end
            2'd2:    begin res = lt | eq; nvf = an | bn;   end
            default: begin res = 1'b0;    nvf = 1'b0;      end
        endcase
        if (an | bn) res = 1'b0;
        return {nvf, res};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 3))
            0:       pick = sp[$urandom_range(0, 7)];
            1:       pick = t;
            2:       pick = {t[31], 8'd0, t[22:0]};
            default: pick = {t[31], 8'd127, 20'd0, t[2:0]};
        endcase
    endfunction

    // one single-op transaction with latency, result, tag and nv checks
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic expy,
                         input logic clr, input logic expnv);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_x1 = a; bus.in_x2 = b;
        bus.in_tag = tag; bus.out_ready = 1'b1; bus.nv_clr = 1'b0;
        #1 chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk({name, "_lat1_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1 chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_y"}, bus.out_y, {31'd0, expy});
        chk({name, "_tag"}, {27'd0, bus.out_tag}, {27'd0, tag});
        bus.nv_clr = clr;
        @(posedge clk);
        #1 bus.nv_clr = 1'b0;
        chk({name, "_nv"}, {31'd0, bus.nv}, {31'd0, expnv});
        chk({name, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
        exp_nv = expnv;
    endtask

    task automatic nv_clear(input string name);
        @(negedge clk);
        bus.nv_clr = 1'b1;
        @(posedge clk);
        #1 bus.nv_clr = 1'b0;
        chk(name, {31'd0, bus.nv}, 32'd0);
        exp_nv = 1'b0;
    endtask

    // one streaming cycle: drive, score output transfer, record input transfer
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic ordy,
                        input logic clr, output logic in_fire);
        exp_t        e;
        logic [1:0]  r;
        logic        out_fire;
        logic        set;
        @(negedge clk);
        chk("nv_stream", {31'd0, bus.nv}, {31'd0, exp_nv});
        bus.in_valid = v; bus.in_op = op; bus.in_x1 = a; bus.in_x2 = b;
        bus.in_tag = tag; bus.out_ready = ordy; bus.nv_clr = clr;
        #1;
        in_fire  = v & bus.in_ready;
        out_fire = bus.out_valid & ordy;
        set      = 1'b0;
        if (out_fire) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL stale_result observed=%h expected=none", bus.out_y);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stream_y", bus.out_y, e.y);
                chk("stream_tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
                set = e.nv;
                outs++;
            end
        end
        if (in_fire) begin
            r = ref_cmp(op, a, b);
            sb.push_back('{y: {31'd0, r[0]}, tag: tag, nv: r[1]});
        end
        exp_nv = set | (exp_nv & ~clr);
        @(posedge clk);
    endtask

    initial begin
        logic f;
        int   acc;
        rstn = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_x1 = 32'd0; bus.in_x2 = 32'd0;
        bus.in_tag = 5'd0; bus.out_ready = 1'b1; bus.nv_clr = 1'b0;

        // reset values
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_nv", {31'd0, bus.nv}, 32'd0);
        chk("rst_out_y", bus.out_y, 32'd0);
        chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // basic compares
        do_op("flt_1_2",   2'd1, 32'h3F800000, 32'h40000000, 5'd3,  1'b1, 1'b0, 1'b0);
        do_op("fle_2_1",   2'd2, 32'h40000000, 32'h3F800000, 5'd7,  1'b0, 1'b0, 1'b0);
        do_op("feq_1_1",   2'd0, 32'h3F800000, 32'h3F800000, 5'd9,  1'b1, 1'b0, 1'b0);
        // signs, zeros, denormals, infinities
        do_op("flt_m1_m2", 2'd1, 32'hBF800000, 32'hC0000000, 5'd10, 1'b0, 1'b0, 1'b0);
        do_op("flt_m2_m1", 2'd1, 32'hC0000000, 32'hBF800000, 5'd11, 1'b1, 1'b0, 1'b0);
        do_op("feq_pz_nz", 2'd0, 32'h00000000, 32'h80000000, 5'd12, 1'b1, 1'b0, 1'b0);
        do_op("flt_nz_pz", 2'd1, 32'h80000000, 32'h00000000, 5'd13, 1'b0, 1'b0, 1'b0);
        do_op("fle_nz_pz", 2'd2, 32'h80000000, 32'h00000000, 5'd14, 1'b1, 1'b0, 1'b0);
        do_op("flt_den",   2'd1, 32'h00000001, 32'h00000002, 5'd15, 1'b1, 1'b0, 1'b0);
        do_op("flt_nden",  2'd1, 32'h80000001, 32'h00000000, 5'd16, 1'b1, 1'b0, 1'b0);
        do_op("fle_inf",   2'd2, 32'hFF800000, 32'h7F800000, 5'd17, 1'b1, 1'b0, 1'b0);
        do_op("rsvd",      2'd3, 32'h3F800000, 32'h3F800000, 5'd18, 1'b0, 1'b0, 1'b0);
        // NaN and NV
        do_op("feq_qnan",  2'd0, 32'h7FC00000, 32'h3F800000, 5'd19, 1'b0, 1'b0, 1'b0);
        do_op("rsvd_snan", 2'd3, 32'h7F800001, 32'h3F800000, 5'd20, 1'b0, 1'b0, 1'b0);
        do_op("feq_snan",  2'd0, 32'h7F800001, 32'h3F800000, 5'd21, 1'b0, 1'b0, 1'b1);
        nv_clear("nv_clr_idle");
        do_op("flt_qnan",  2'd1, 32'h7FC00000, 32'h3F800000, 5'd22, 1'b0, 1'b0, 1'b1);
        nv_clear("nv_clr_idle2");
        do_op("fle_qnan_clr", 2'd2, 32'h7FC00000, 32'h3F800000, 5'd23, 1'b0, 1'b1, 1'b1);
        nv_clear("nv_clr_idle3");

        // backpressure: 2 accepted while stalled, then 5 in order one per cycle
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 2'd1, 32'h3F800000 + 32'(acc), 32'h3F800002, 5'd24 + 5'(acc),
                 1'b0, 1'b0, f);
            if (f) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        #1 chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        outs = 0;
        for (int c = 0; c < 5; c++) begin
            step(acc < 5, 2'd1, 32'h3F800000 + 32'(acc), 32'h3F800002, 5'd24 + 5'(acc),
                 1'b1, 1'b0, f);
            if (f) acc++;
        end
        chk("bp_outs", 32'(outs), 32'd5);
        chk("bp_all_in", 32'(acc), 32'd5);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // reset with two ops in flight and nv set
        do_op("flt_qnan2", 2'd1, 32'h7FC00000, 32'h3F800000, 5'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd1, 32'h3F800000, 32'h40000000, 5'd2, 1'b0, 1'b0, f);
        step(1'b1, 2'd1, 32'h3F800000, 32'h40000000, 5'd3, 1'b0, 1'b0, f);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_nv", {31'd0, bus.nv}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.delete();
        exp_nv = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("mid_rst_release_ready", {31'd0, bus.in_ready}, 32'd1);
        outs = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, f);
        end
        chk("mid_rst_no_stale", 32'(outs), 32'd0);

        // random streaming against the reference model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a, b;
            logic [31:0] t;
            a = pick();
            t = $urandom;
            case (t[1:0])
                2'd0:    b = a;
                2'd1:    b = {~a[31], a[30:0]};
                default: b = pick();
            endcase
            step(t[2] | t[3], t[5:4], a, b, t[10:6], t[11] | t[12], t[16:13] == 4'd0, f);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, f);
        end
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
